// File: rtl/wb_cpu_master_bridge.sv
// Single-outstanding Wishbone classic master: one CPU request in, one bus transfer,
// one response beat out, with a bounded ack timeout and a turnaround cycle between transfers.
module wb_cpu_master_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_valid_i,
  output logic        cpu_req_ready_o,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic        cpu_rsp_valid_o,
  output logic [31:0] cpu_rsp_rdata_o,
  output logic        cpu_rsp_err_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_d, wdata_d, rdata_d;
  logic [3:0]        sel_d;
  logic              we_d, stb_d, cyc_d, rsp_valid_d, err_d, busy_d;

  // Ready is the only combinational output; it must drop with rst_ni immediately.
  assign cpu_req_ready_o = (state_q == IDLE) && rst_ni;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = wb_addr_o;
    wdata_d     = wb_data_o;
    we_d        = wb_we_o;
    sel_d       = wb_sel_o;
    stb_d       = wb_stb_o;
    cyc_d       = wb_cyc_o;
    rsp_valid_d = 1'b0;
    rdata_d     = cpu_rsp_rdata_o;
    err_d       = cpu_rsp_err_o;

    unique case (state_q)
      IDLE: begin
        stb_d = 1'b0;
        cyc_d = 1'b0;
        if (cpu_req_valid_i && cpu_req_ready_o) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          cnt_d   = '0;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (wb_ack_i) begin
          rdata_d     = wb_we_o ? 32'd0 : wb_data_i;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d     = 32'd0;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          stb_d       = 1'b0;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stb_d   = 1'b0;
        cyc_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      wb_addr_o       <= 32'd0;
      wb_data_o       <= 32'd0;
      wb_we_o         <= 1'b0;
      wb_sel_o        <= 4'd0;
      wb_stb_o        <= 1'b0;
      wb_cyc_o        <= 1'b0;
      cpu_rsp_valid_o <= 1'b0;
      cpu_rsp_rdata_o <= 32'd0;
      cpu_rsp_err_o   <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wb_addr_o       <= addr_d;
      wb_data_o       <= wdata_d;
      wb_we_o         <= we_d;
      wb_sel_o        <= sel_d;
      wb_stb_o        <= stb_d;
      wb_cyc_o        <= cyc_d;
      cpu_rsp_valid_o <= rsp_valid_d;
      cpu_rsp_rdata_o <= rdata_d;
      cpu_rsp_err_o   <= err_d;
      busy_o          <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_cpu_master_bridge.sv
// Bench for wb_cpu_master_bridge: slave model with configurable ack delay, a transaction-level
// timeline model compared every cycle, plus literal latency/data expectations.
module tb_wb_cpu_master_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cpu_req_valid_i;
  logic        cpu_req_ready_o;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic        cpu_we_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_rsp_valid_o;
  logic [31:0] cpu_rsp_rdata_o;
  logic        cpu_rsp_err_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i = 32'hDEAD_BEEF;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        busy_o;

  always #5 clk = ~clk;

  wb_cpu_master_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_ready_o(cpu_req_ready_o),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_rsp_valid_o(cpu_rsp_valid_o), .cpu_rsp_rdata_o(cpu_rsp_rdata_o), .cpu_rsp_err_o(cpu_rsp_err_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .busy_o(busy_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Slave: acks on the ack_at-th consecutive stb cycle (0 = never); ack_force injects stray acks.
  int          ack_at = 2;
  logic        ack_force = 1'b0;
  logic        slave_ack = 1'b0;
  int          n = 0;
  logic [31:0] mem [16];

  assign wb_ack_i = slave_ack | ack_force;

  always @(negedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
    end
    if (wb_cyc_o && wb_stb_o) begin
      n <= n + 1;
      if (n + 1 == ack_at) begin
        slave_ack <= 1'b1;
        if (wb_we_o) begin
          mem[wb_addr_o[5:2]] <= merge(mem[wb_addr_o[5:2]], wb_data_o, wb_sel_o);
          wb_data_i <= 32'hDEAD_BEEF;
        end else begin
          wb_data_i <= mem[wb_addr_o[5:2]];
        end
      end else begin
        slave_ack <= 1'b0;
        wb_data_i <= 32'hDEAD_BEEF;
      end
    end else begin
      n         <= 0;
      slave_ack <= 1'b0;
      wb_data_i <= 32'hDEAD_BEEF;
    end
  end

  // Timeline model: k = cycles since acceptance (0 = idle); bus phase lasts blen cycles, then one response cycle.
  int          k = 0;
  int          blen = 1;
  logic        to_flag = 1'b0;
  logic        armed = 1'b0;
  logic [31:0] e_addr = 32'd0, e_data = 32'd0, e_rdata = 32'd0;
  logic        e_we = 1'b0, e_err = 1'b0;
  logic [3:0]  e_sel = 4'd0;
  logic [31:0] shadow [16];

  function automatic bit acks_in_time(input int a);
    return (a >= 1) && (a <= TMO);
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      k <= 0; e_addr <= 32'd0; e_data <= 32'd0; e_we <= 1'b0; e_sel <= 4'd0;
      e_rdata <= 32'd0; e_err <= 1'b0; armed <= 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] <= 32'd0;
    end else if (k == 0) begin
      if (cpu_req_valid_i) begin
        k <= 1;
        e_addr <= cpu_addr_i; e_data <= cpu_wdata_i; e_we <= cpu_we_i; e_sel <= cpu_sel_i;
        blen <= acks_in_time(ack_at) ? ack_at : TMO;
        to_flag <= !acks_in_time(ack_at);
      end
    end else if (k == blen) begin
      k <= k + 1;
      e_err <= to_flag;
      e_rdata <= (e_we || to_flag) ? 32'd0 : shadow[e_addr[5:2]];
      if (e_we && !to_flag) shadow[e_addr[5:2]] <= merge(shadow[e_addr[5:2]], e_data, e_sel);
    end else if (k == blen + 1) begin
      k <= 0;
    end else begin
      k <= k + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("ready",     32'(cpu_req_ready_o), 32'(rst_ni && k == 0));
      chk("busy",      32'(busy_o),          32'(k != 0));
      chk("cyc",       32'(wb_cyc_o),        32'(k >= 1 && k <= blen));
      chk("stb",       32'(wb_stb_o),        32'(k >= 1 && k <= blen));
      chk("we",        32'(wb_we_o),         32'(e_we));
      chk("addr",      wb_addr_o,            e_addr);
      chk("wdata",     wb_data_o,            e_data);
      chk("sel",       32'(wb_sel_o),        32'(e_sel));
      chk("rsp_valid", 32'(cpu_rsp_valid_o), 32'(k != 0 && k == blen + 1));
      chk("rsp_rdata", cpu_rsp_rdata_o,      e_rdata);
      chk("rsp_err",   32'(cpu_rsp_err_o),   32'(e_err));
    end
  end

  // Measurement of the last response: latency from acceptance and stb length.
  int          mcnt = 0, slen = 0, lat = 0, last_slen = 0, rsp_count = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  always @(posedge clk) begin
    if (cpu_req_valid_i && cpu_req_ready_o) begin
      mcnt <= 1;
      slen <= 0;
    end else begin
      mcnt <= mcnt + 1;
      if (wb_stb_o) slen <= slen + 1;
    end
    if (cpu_rsp_valid_o) begin
      lat        <= mcnt;
      last_slen  <= slen;
      last_rdata <= cpu_rsp_rdata_o;
      last_err   <= cpu_rsp_err_o;
      rsp_count  <= rsp_count + 1;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    bit got;
    got = 1'b0;
    cpu_addr_i = a; cpu_wdata_i = d; cpu_we_i = w; cpu_sel_i = s;
    cpu_req_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_req_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_wait", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic cycles(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  int rc;

  initial begin
    rst_ni = 1'b0; cpu_req_valid_i = 1'b0;
    cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0; cpu_we_i = 1'b0; cpu_sel_i = 4'd0;
    cycles(3);
    rst_ni = 1'b1;
    cycles(2);
    chk("reset_ready", 32'(cpu_req_ready_o), 32'd1);
    chk("reset_cyc",   32'(wb_cyc_o),        32'd0);

    // LED-style slave write, then read back
    ack_at = 2;
    send(32'h4, 32'h0000_00A5, 1'b1, 4'hF); cpu_req_valid_i = 1'b0; cycles(5);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_stb_len", 32'(last_slen), 32'd2);
    chk("t1_err", 32'(last_err), 32'd0);
    chk("t1_rdata", last_rdata, 32'd0);

    send(32'h4, 32'h0, 1'b0, 4'hF); cpu_req_valid_i = 1'b0; cycles(5);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_rdata", last_rdata, 32'h0000_00A5);

    // Zero-wait partial-lane write, then read back
    ack_at = 1;
    send(32'h8, 32'h1234_5678, 1'b1, 4'h3); cpu_req_valid_i = 1'b0; cycles(4);
    chk("zw_lat", 32'(lat), 32'd2);
    ack_at = 2;
    send(32'h8, 32'h0, 1'b0, 4'hF); cpu_req_valid_i = 1'b0; cycles(5);
    chk("sel_rdata", last_rdata, 32'h0000_5678);

    // Timeout with no ack
    ack_at = 0;
    send(32'h4, 32'h0, 1'b0, 4'hF); cpu_req_valid_i = 1'b0; cycles(20);
    chk("t3_stb_len", 32'(last_slen), 32'd16);
    chk("t3_err", 32'(last_err), 32'd1);
    chk("t3_rdata", last_rdata, 32'd0);
    chk("t3_lat", 32'(lat), 32'd17);

    // Ack in the final allowed cycle
    ack_at = TMO;
    send(32'h4, 32'h0, 1'b0, 4'hF); cpu_req_valid_i = 1'b0; cycles(20);
    chk("t4_stb_len", 32'(last_slen), 32'd16);
    chk("t4_err", 32'(last_err), 32'd0);
    chk("t4_rdata", last_rdata, 32'h0000_00A5);

    // Back-to-back with valid held high
    ack_at = 2;
    rc = rsp_count;
    send(32'h10, 32'hCAFE_0001, 1'b1, 4'hF);
    send(32'h10, 32'h0, 1'b0, 4'hF);
    cpu_req_valid_i = 1'b0; cycles(8);
    chk("t5_rsp_count", 32'(rsp_count), 32'(rc + 2));
    chk("t5_rdata", last_rdata, 32'hCAFE_0001);

    // Reset during the second bus cycle, then a stray ack
    ack_at = 0;
    rc = rsp_count;
    send(32'h4, 32'h0, 1'b0, 4'hF); cpu_req_valid_i = 1'b0;
    cycles(1);
    rst_ni = 1'b0;
    cycles(1);
    rst_ni = 1'b1;
    ack_force = 1'b1;
    cycles(1);
    ack_force = 1'b0;
    cycles(3);
    chk("t6_no_rsp", 32'(rsp_count), 32'(rc));
    chk("t6_ready", 32'(cpu_req_ready_o), 32'd1);
    chk("t6_cyc", 32'(wb_cyc_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
